acc_bias_unit: RTL and testbench
================================

ACC_BIAS_UNIT -- requirements
Module: acc_bias_unit

Interface
REQ-001 SHALL have parameter P_BW, default 16, width of each signed partial-sum input.
REQ-002 SHALL have parameter B_BW, default 16, width of each signed bias input.
REQ-003 SHALL have parameter AB_BW, default 21, width of each signed accumulated+bias output.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  one-cycle pulse beginning an accumulation job.
REQ-007 SHALL have port i_acc_len  input  4  number of partial sums minus one (1..16 sums).
REQ-008 SHALL have ports i_bias0/1/2  input  B_BW each  per-lane signed bias.
REQ-009 SHALL have port i_psum_valid  input  1  partial sums valid this cycle.
REQ-010 SHALL have ports i_psum0/1/2  input  P_BW each  per-lane signed partial sums.
REQ-011 SHALL have port o_busy  output  1  high in every non-IDLE state.
REQ-012 SHALL have port o_acc_bias_valid  output  1  one-cycle result strobe.
REQ-013 SHALL have port o_bound_en  output  1  drives the downstream clipping stage enable.
REQ-014 SHALL have ports o_acc_bias0/1/2  output  AB_BW each  signed sum of partial sums plus bias.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, BIAS, OUT.
REQ-016 SHALL, in IDLE on i_start=1, latch i_acc_len and all three biases, clear the lane accumulators and the beat counter, then enter ACC.
REQ-017 SHALL ignore i_psum_valid in the IDLE cycle, including the cycle that carries i_start.
REQ-018 SHALL ignore i_start in every state except IDLE.
REQ-019 SHALL, in ACC, add the sign-extended i_psumN to lane accumulator N and increment the beat counter on each cycle with i_psum_valid=1. Cycles with i_psum_valid=0 SHALL hold all state.
REQ-020 SHALL move from ACC to BIAS on the valid beat where beat counter equals the latched length.
REQ-021 SHALL, in BIAS, add the sign-extended latched bias to each lane accumulator and then enter OUT.
REQ-022 SHALL, in OUT, assert o_acc_bias_valid and o_bound_en for exactly one cycle, then return to IDLE.
REQ-023 SHALL hold o_acc_bias0/1/2 stable from the OUT cycle until the next OUT cycle.
REQ-024 SHALL have latency such that the last valid beat in cycle t gives o_acc_bias_valid in cycle t+2.
REQ-025 SHALL size lane accumulators at AB_BW bits in two's complement. Sixteen P_BW sums plus one B_BW bias SHALL fit without overflow, so no saturation is applied.
REQ-026 SHALL allow i_start in the cycle after OUT, giving back-to-back jobs with one IDLE cycle between them.

Reset
REQ-027 SHALL, while rst_n=0, force the FSM to IDLE and clear the accumulators, the counter and all latched values. Outputs SHALL be o_busy=0, o_acc_bias_valid=0, o_bound_en=0, o_acc_bias0/1/2=0.
REQ-028 SHALL, on reset asserted mid-job, discard the job without producing a result strobe.

Configuration
REQ-029 SHALL, with macro ACC_BIAS_PERF_CNT_EN defined, add output o_job_cnt (16 bits). It counts OUT cycles, wraps from 65535 to 0, and resets to 0.
REQ-030 SHALL, without ACC_BIAS_PERF_CNT_EN, have no o_job_cnt port and no counter logic.

Structure
REQ-031 SHALL take P_BW, B_BW and AB_BW defaults and the FSM state encoding from shared package acc_bias_pkg.
REQ-032 SHALL use one sub-module, acc_lane, instantiated three times: a single-lane accumulator with clear, add-psum and add-bias controls.

Verification
REQ-033 SHALL cover this case: len=0, psums (5,-3,100), bias (1,1,-200) -> outputs (6,-2,-100), valid at t+2.
REQ-034 SHALL cover this case: len=15, every psum lane0=32767 and lane1=-32768, bias 32767/-32768 -> 557039 / -557056, no overflow.
REQ-035 SHALL cover this case: len=3 with i_psum_valid gaps of 2 cycles between beats -> only the 4 valid beats are summed, o_busy high throughout.
REQ-036 SHALL cover this case: i_start and i_psum_valid in the same IDLE cycle, then i_start again during ACC -> first psum excluded, second start ignored.
REQ-037 SHALL cover this case: rst_n pulsed low during ACC after 2 beats -> all outputs 0, no valid strobe, next job correct.
REQ-038 SHALL cover this case: ACC_BIAS_PERF_CNT_EN defined with 3 back-to-back jobs -> o_job_cnt=3, o_bound_en equal to o_acc_bias_valid every cycle.

Source files
------------

// File: rtl/acc_bias_pkg.sv
// Shared widths and FSM encoding for the accumulate-plus-bias unit.
package acc_bias_pkg;

    localparam int P_BW_DEF  = 16;
    localparam int B_BW_DEF  = 16;
    localparam int AB_BW_DEF = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        BIAS = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/acc_lane.sv
// Single-lane signed accumulator with clear, add-psum and add-bias controls.
// The result register is loaded on the bias step and holds until the next one.
module acc_lane
    import acc_bias_pkg::*;
#(
    parameter int P_BW  = P_BW_DEF,
    parameter int B_BW  = B_BW_DEF,
    parameter int AB_BW = AB_BW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    add_psum,
    input  logic                    add_bias,
    input  logic signed [P_BW-1:0]  psum,
    input  logic signed [B_BW-1:0]  bias,
    output logic signed [AB_BW-1:0] result
);

    logic signed [AB_BW-1:0] acc_r;
    logic signed [AB_BW-1:0] result_r;
    logic signed [AB_BW-1:0] psum_ext_s;
    logic signed [AB_BW-1:0] bias_ext_s;
    logic signed [AB_BW-1:0] acc_nxt_s;

    assign psum_ext_s = AB_BW'(psum);
    assign bias_ext_s = AB_BW'(bias);

    // Next accumulator value; clear wins over both add paths.
    always_comb begin
        acc_nxt_s = acc_r;
        if (clr) begin
            acc_nxt_s = {AB_BW{1'b0}};
        end else if (add_psum) begin
            acc_nxt_s = acc_r + psum_ext_s;
        end else if (add_bias) begin
            acc_nxt_s = acc_r + bias_ext_s;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Accumulator and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {AB_BW{1'b0}};
            result_r <= {AB_BW{1'b0}};
        end else begin
            acc_r <= acc_nxt_s;
            if (add_bias) begin
                result_r <= acc_nxt_s;
            end
        end
    end

    assign result = result_r;

endmodule

// File: rtl/acc_bias_unit.sv
// Three-lane accumulate-then-bias unit: sums 1..16 partial-sum beats per lane, adds a bias.
// Optional job counter output o_job_cnt is built when ACC_BIAS_PERF_CNT_EN is defined.
module acc_bias_unit
    import acc_bias_pkg::*;
#(
    parameter int P_BW  = P_BW_DEF,
    parameter int B_BW  = B_BW_DEF,
    parameter int AB_BW = AB_BW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [3:0]              i_acc_len,
    input  logic signed [B_BW-1:0]  i_bias0,
    input  logic signed [B_BW-1:0]  i_bias1,
    input  logic signed [B_BW-1:0]  i_bias2,
    input  logic                    i_psum_valid,
    input  logic signed [P_BW-1:0]  i_psum0,
    input  logic signed [P_BW-1:0]  i_psum1,
    input  logic signed [P_BW-1:0]  i_psum2,
    output logic                    o_busy,
    output logic                    o_acc_bias_valid,
    output logic                    o_bound_en,
    output logic signed [AB_BW-1:0] o_acc_bias0,
    output logic signed [AB_BW-1:0] o_acc_bias1,
    output logic signed [AB_BW-1:0] o_acc_bias2
`ifdef ACC_BIAS_PERF_CNT_EN
    ,
    output logic [15:0]             o_job_cnt
`endif
);

    state_t                 state_r;
    logic [3:0]             len_r;
    logic [3:0]             cnt_r;
    logic signed [B_BW-1:0] bias0_r;
    logic signed [B_BW-1:0] bias1_r;
    logic signed [B_BW-1:0] bias2_r;
    logic                   busy_r;
    logic                   valid_r;
    logic                   clr_s;
    logic                   add_psum_s;
    logic                   add_bias_s;

    // Lane control strobes decoded from the current state.
    always_comb begin
        clr_s      = 1'b0;
        add_psum_s = 1'b0;
        add_bias_s = 1'b0;
        case (state_r)
            IDLE:    clr_s      = i_start;
            ACC:     add_psum_s = i_psum_valid;
            BIAS:    add_bias_s = 1'b1;
            OUT:     clr_s      = 1'b0;
            default: clr_s      = 1'b0;
        endcase
    end

    // Job FSM with registered busy/valid outputs and latched job parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            len_r   <= 4'd0;
            cnt_r   <= 4'd0;
            bias0_r <= {B_BW{1'b0}};
            bias1_r <= {B_BW{1'b0}};
            bias2_r <= {B_BW{1'b0}};
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    busy_r  <= i_start;
                    if (i_start) begin
                        len_r   <= i_acc_len;
                        cnt_r   <= 4'd0;
                        bias0_r <= i_bias0;
                        bias1_r <= i_bias1;
                        bias2_r <= i_bias2;
                        state_r <= ACC;
                    end
                end
                ACC: begin
                    busy_r <= 1'b1;
                    if (i_psum_valid) begin
                        cnt_r <= cnt_r + 4'd1;
                        if (cnt_r == len_r) begin
                            state_r <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    busy_r  <= 1'b1;
                    valid_r <= 1'b1;
                    state_r <= OUT;
                end
                OUT: begin
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_busy           = busy_r;
    assign o_acc_bias_valid = valid_r;
    assign o_bound_en       = valid_r;

    acc_lane #(.P_BW(P_BW), .B_BW(B_BW), .AB_BW(AB_BW)) u_lane0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .add_psum (add_psum_s),
        .add_bias (add_bias_s),
        .psum     (i_psum0),
        .bias     (bias0_r),
        .result   (o_acc_bias0)
    );

    acc_lane #(.P_BW(P_BW), .B_BW(B_BW), .AB_BW(AB_BW)) u_lane1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .add_psum (add_psum_s),
        .add_bias (add_bias_s),
        .psum     (i_psum1),
        .bias     (bias1_r),
        .result   (o_acc_bias1)
    );

    acc_lane #(.P_BW(P_BW), .B_BW(B_BW), .AB_BW(AB_BW)) u_lane2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .add_psum (add_psum_s),
        .add_bias (add_bias_s),
        .psum     (i_psum2),
        .bias     (bias2_r),
        .result   (o_acc_bias2)
    );

`ifdef ACC_BIAS_PERF_CNT_EN
    logic [15:0] job_cnt_r;

    // Counts OUT cycles; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_cnt_r <= 16'd0;
        end else if (state_r == OUT) begin
            job_cnt_r <= job_cnt_r + 16'd1;
        end
    end

    assign o_job_cnt = job_cnt_r;
`endif

endmodule

// File: tb/tb_acc_bias_unit.sv
// Table-driven, scoreboard-checked bench for acc_bias_unit.
module tb_acc_bias_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [3:0]  i_acc_len;
    logic [15:0] i_bias0, i_bias1, i_bias2;
    logic        i_psum_valid;
    logic [15:0] i_psum0, i_psum1, i_psum2;
    logic        o_busy, o_acc_bias_valid, o_bound_en;
    logic [20:0] o_acc_bias0, o_acc_bias1, o_acc_bias2;
`ifdef ACC_BIAS_PERF_CNT_EN
    logic [15:0] o_job_cnt;
`endif

    acc_bias_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_acc_len        (i_acc_len),
        .i_bias0          (i_bias0),
        .i_bias1          (i_bias1),
        .i_bias2          (i_bias2),
        .i_psum_valid     (i_psum_valid),
        .i_psum0          (i_psum0),
        .i_psum1          (i_psum1),
        .i_psum2          (i_psum2),
        .o_busy           (o_busy),
        .o_acc_bias_valid (o_acc_bias_valid),
        .o_bound_en       (o_bound_en),
        .o_acc_bias0      (o_acc_bias0),
        .o_acc_bias1      (o_acc_bias1),
        .o_acc_bias2      (o_acc_bias2)
`ifdef ACC_BIAS_PERF_CNT_EN
        ,
        .o_job_cnt        (o_job_cnt)
`endif
    );

    always #5 clk = ~clk;

    // len, gap, bias[3], psum base[3], psum step per beat[3], expected[3]
    typedef struct packed {
        int len; int gap;
        int b0; int b1; int b2;
        int p0; int p1; int p2;
        int s0; int s1; int s2;
        int e0; int e1; int e2;
    } vec_t;

    typedef struct packed {
        int e0; int e1; int e2; int cyc;
    } exp_t;

    vec_t vecs [5];
    exp_t sb_q [$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   jobs_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"},  int'(o_busy), 0);
        check({name, "_valid"}, int'(o_acc_bias_valid), 0);
        check({name, "_bound"}, int'(o_bound_en), 0);
        check({name, "_acc0"},  int'($signed(o_acc_bias0)), 0);
        check({name, "_acc1"},  int'($signed(o_acc_bias1)), 0);
        check({name, "_acc2"},  int'($signed(o_acc_bias2)), 0);
`ifdef ACC_BIAS_PERF_CNT_EN
        check({name, "_jobcnt"}, int'(o_job_cnt), 0);
`endif
    endtask

    // Output monitor: pops the scoreboard on each result strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_acc_bias_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("acc0", int'($signed(o_acc_bias0)), e.e0);
                    check("acc1", int'($signed(o_acc_bias1)), e.e1);
                    check("acc2", int'($signed(o_acc_bias2)), e.e2);
                    check("latency_cycle", cyc, e.cyc);
                    check("bound_en_on_valid", int'(o_bound_en), 1);
                    jobs_done++;
                end
            end else if (o_bound_en) begin
                check("bound_en_without_valid", 1, 0);
            end
        end
    end

    // Called right at a rising edge; drives one job and pushes its expectation.
    task automatic do_job(input vec_t v, input bit dirty);
        exp_t e;
        #1;
        i_start      = 1'b1;
        i_acc_len    = 4'(v.len);
        i_bias0      = 16'(v.b0);
        i_bias1      = 16'(v.b1);
        i_bias2      = 16'(v.b2);
        i_psum_valid = dirty;
        i_psum0      = 16'd1000;
        i_psum1      = 16'd1000;
        i_psum2      = 16'd1000;
        for (int b = 0; b <= v.len; b++) begin
            for (int g = 0; g < ((b == 0) ? 0 : v.gap); g++) begin
                @(posedge clk); #1;
                i_start      = 1'b0;
                i_psum_valid = 1'b0;
                check("busy_gap", int'(o_busy), 1);
            end
            @(posedge clk); #1;
            i_start = dirty && (b == 0);
            if (dirty) begin
                i_acc_len = 4'd0;
                i_bias0   = 16'h1234;
                i_bias1   = 16'h1234;
                i_bias2   = 16'h1234;
            end
            i_psum_valid = 1'b1;
            i_psum0      = 16'(v.p0 + b * v.s0);
            i_psum1      = 16'(v.p1 + b * v.s1);
            i_psum2      = 16'(v.p2 + b * v.s2);
            check("busy_beat", int'(o_busy), 1);
            if (b == v.len) begin
                e = '{v.e0, v.e1, v.e2, cyc + 2};
                sb_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        i_start      = 1'b0;
        i_psum_valid = 1'b0;
    endtask

    // Returns at the rising edge after the last result was consumed.
    task automatic wait_drain();
        for (int w = 0; w < 12 && sb_q.size() != 0; w++) @(posedge clk);
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_acc_len = 4'd0;
        i_bias0 = 16'd0; i_bias1 = 16'd0; i_bias2 = 16'd0;
        i_psum_valid = 1'b0; i_psum0 = 16'd0; i_psum1 = 16'd0; i_psum2 = 16'd0;

        vecs[0] = '{0, 0, 1, 1, -200, 5, -3, 100, 0, 0, 0, 6, -2, -100};
        vecs[1] = '{15, 0, 32767, -32768, 0, 32767, -32768, 0, 0, 0, 0, 557039, -557056, 0};
        vecs[2] = '{3, 2, 10, -10, 0, 1, 2, 3, 1, 1, 1, 20, 4, 18};
        vecs[3] = '{1, 1, 0, 0, 0, -100, 200, -32768, 50, -300, 0, -150, 100, -65536};
        vecs[4] = '{7, 0, -1, 100, -5, 1000, -1, 0, -300, 0, 1, -401, 92, 23};

        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);

        // Table jobs, each started in the IDLE cycle right after OUT.
        for (int i = 0; i < 5; i++) begin
            do_job(vecs[i], 1'b0);
            wait_drain();
        end

        // Start with psum_valid in IDLE, then a second start during ACC.
        do_job(vecs[2], 1'b1);
        wait_drain();

        // Reset in the middle of a job after two beats.
        #1;
        i_start = 1'b1; i_acc_len = 4'd3;
        i_bias0 = 16'd7; i_bias1 = 16'd7; i_bias2 = 16'd7;
        @(posedge clk); #1;
        i_start = 1'b0; i_psum_valid = 1'b1;
        i_psum0 = 16'd9; i_psum1 = 16'd9; i_psum2 = 16'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_psum_valid = 1'b0;
        check("mid_busy_before_rst", int'(o_busy), 1);
        rst_n = 1'b0;
        #1 check_zero("mid_reset");
        jobs_done = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("no_strobe_after_rst", jobs_done, 0);

        // Three back-to-back jobs after the aborted one.
        do_job(vecs[0], 1'b0);
        wait_drain();
        do_job(vecs[3], 1'b0);
        wait_drain();
        do_job(vecs[4], 1'b0);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("jobs_after_rst", jobs_done, 3);
        check("hold_acc0", int'($signed(o_acc_bias0)), -401);
        check("hold_acc1", int'($signed(o_acc_bias1)), 92);
        check("hold_acc2", int'($signed(o_acc_bias2)), 23);
        check("idle_busy", int'(o_busy), 0);
`ifdef ACC_BIAS_PERF_CNT_EN
        check("job_cnt", int'(o_job_cnt), 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
